// File: rtl/ps2_direction_decoder.sv
// ps2_direction_decoder: decodes PS/2 scan codes into registered per-player lightbike headings
module ps2_direction_decoder #(
    parameter logic [7:0] INIT_DIR       = 8'h8D,
    parameter int         REJECT_REVERSE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  scan_code,
    input  logic        scan_valid,
    input  logic        load_init,
    output logic [7:0]  dir,
    output logic [3:0]  dir_pulse,
    output logic [15:0] key_held
);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
    // Key table: byte slot 4p+d holds player p's code for direction d (0=up,1=right,2=down,3=left)
    localparam logic [127:0] KEY_MAP = {
        8'h6B, 8'h73, 8'h74, 8'h75,
        8'h3B, 8'h42, 8'h4B, 8'h43,
        8'h2B, 8'h34, 8'h33, 8'h2C,
        8'h1C, 8'h1B, 8'h23, 8'h1D
    };
    state_t      state_q, state_d;
    logic [7:0]  dir_q, dir_d;
    logic [3:0]  pulse_q, pulse_d;
    logic [15:0] held_q, held_d;
    logic        is_prefix, is_final, is_break, hit;
    logic [1:0]  hp, hd, cur;
    assign is_prefix = (scan_code == 8'hE0) || (scan_code == 8'hF0);
    assign is_final  = scan_valid && !is_prefix;
    assign is_break  = (state_q == BRK) || (state_q == EXT_BRK);
    // State and output registers; the prefix state only gates break/make, outputs are fully registered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= INIT_DIR;
            pulse_q <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
        end
    end
    // Prefix tracking: E0 drops any pending break, F0 keeps the extended flag, finals return to IDLE
    always_comb begin
        state_d = state_q;
        if (load_init)
            state_d = IDLE;
        else if (scan_valid)
            state_d = (scan_code == 8'hE0) ? EXT :
                      (scan_code == 8'hF0) ? (((state_q == EXT) || (state_q == EXT_BRK)) ? EXT_BRK : BRK) :
                      IDLE;
    end
    // Key lookup and heading resolution; the extended prefix never affects which player matches
    always_comb begin
        hit     = 1'b0;
        hp      = 2'd0;
        hd      = 2'd0;
        dir_d   = dir_q;
        pulse_d = '0;
        held_d  = held_q;
        for (int i = 0; i < 16; i++)
            if (scan_code == KEY_MAP[i*8 +: 8]) begin
                hit = 1'b1;
                hp  = i[3:2];
                hd  = i[1:0];
            end
        cur = dir_q[{hp, 1'b0} +: 2];
        if (load_init) begin
            dir_d  = INIT_DIR;
            held_d = '0;
        end else if (is_final && hit) begin
            held_d[{hp, hd}] = !is_break;
            if (!is_break && hd != cur && !((REJECT_REVERSE != 0) && hd == (cur ^ 2'd2))) begin
                dir_d[{hp, 1'b0} +: 2] = hd;
                pulse_d[hp]            = 1'b1;
            end
        end
    end
    assign dir       = dir_q;
    assign dir_pulse = pulse_q;
    assign key_held  = held_q;
endmodule

// File: tb/tb_ps2_direction_decoder.sv
// tb_ps2_direction_decoder: directed plus randomized checking against a behavioural key-table model
module tb_ps2_direction_decoder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  scan_code = 8'h00;
    logic        scan_valid = 1'b0;
    logic        load_init = 1'b0;
    logic [7:0]  dir;
    logic [3:0]  dir_pulse;
    logic [15:0] key_held;

    ps2_direction_decoder dut (
        .clock(clock), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
        .load_init(load_init), .dir(dir), .dir_pulse(dir_pulse), .key_held(key_held)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    logic [7:0] keys [4][4] = '{
        '{8'h1D, 8'h23, 8'h1B, 8'h1C},
        '{8'h2C, 8'h33, 8'h34, 8'h2B},
        '{8'h43, 8'h4B, 8'h42, 8'h3B},
        '{8'h75, 8'h74, 8'h73, 8'h6B}
    };
    int          m_dir [4];
    logic [3:0]  m_pulse;
    logic [15:0] m_held;
    bit          m_brk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] packed_dir();
        logic [7:0] r;
        for (int p = 0; p < 4; p++) r[2*p +: 2] = 2'(m_dir[p]);
        return r;
    endfunction

    task automatic model_reset();
        m_dir   = '{1, 3, 0, 2};
        m_pulse = '0;
        m_held  = '0;
        m_brk   = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] c, input logic li);
        int fp, fd;
        bit found;
        m_pulse = '0;
        if (li) begin
            model_reset();
        end else if (v) begin
            if (c == 8'hE0) m_brk = 1'b0;
            else if (c == 8'hF0) m_brk = 1'b1;
            else begin
                found = 1'b0;
                fp = 0;
                fd = 0;
                for (int p = 0; p < 4; p++)
                    for (int d = 0; d < 4; d++)
                        if (keys[p][d] == c) begin found = 1'b1; fp = p; fd = d; end
                if (found) begin
                    if (m_brk) m_held[4*fp+fd] = 1'b0;
                    else begin
                        m_held[4*fp+fd] = 1'b1;
                        if (fd != m_dir[fp] && fd != (m_dir[fp] + 2) % 4) begin
                            m_dir[fp] = fd;
                            m_pulse[fp] = 1'b1;
                        end
                    end
                end
                m_brk = 1'b0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".dir"}, {8'h00, dir}, {8'h00, packed_dir()});
        check({tag, ".pulse"}, {12'h000, dir_pulse}, {12'h000, m_pulse});
        check({tag, ".held"}, key_held, m_held);
    endtask

    task automatic step(input logic v, input logic [7:0] c, input logic li);
        scan_valid = v;
        scan_code  = c;
        load_init  = li;
        @(posedge clock);
        model_step(v, c, li);
        #1;
        scan_valid = 1'b0;
        load_init  = 1'b0;
        compare_all("step");
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        model_reset();
        compare_all("async_reset");
        reset = 1'b0;
    endtask

    logic [7:0] c;
    initial begin
        model_reset();
        #12;
        compare_all("reset");
        check("reset.dir_const", {8'h00, dir}, 16'h008D);
        reset = 1'b0;
        @(posedge clock);
        #1;
        step(1'b1, 8'h1D, 1'b0);
        check("p0_up.dir", {14'd0, dir[1:0]}, 16'd0);
        check("p0_up.pulse", {12'd0, dir_pulse}, 16'h0001);
        check("p0_up.held", {15'd0, key_held[0]}, 16'd1);
        step(1'b0, 8'h00, 1'b0);
        check("p0_up.pulse_end", {12'd0, dir_pulse}, 16'h0000);
        step(1'b1, 8'h23, 1'b0);
        step(1'b1, 8'h1C, 1'b0);
        check("p0_rev.dir", {14'd0, dir[1:0]}, 16'd1);
        check("p0_rev.held", {15'd0, key_held[3]}, 16'd1);
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'h1C, 1'b0);
        check("p0_brk.held", {15'd0, key_held[3]}, 16'd0);
        step(1'b1, 8'hE0, 1'b0);
        step(1'b1, 8'h75, 1'b0);
        check("p3_rev.dir", {14'd0, dir[7:6]}, 16'd2);
        check("p3_rev.held", {15'd0, key_held[12]}, 16'd1);
        step(1'b1, 8'hE0, 1'b0);
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'h75, 1'b0);
        check("p3_brk.held", {15'd0, key_held[12]}, 16'd0);
        step(1'b1, 8'hE0, 1'b0);
        step(1'b1, 8'h6B, 1'b0);
        check("p3_left.dir", {14'd0, dir[7:6]}, 16'd3);
        check("p3_left.pulse", {12'd0, dir_pulse}, 16'h0008);
        step(1'b1, 8'h73, 1'b0);
        check("p3_kp.dir", {14'd0, dir[7:6]}, 16'd2);
        check("p3_kp.pulse", {12'd0, dir_pulse}, 16'h0008);
        step(1'b1, 8'h2B, 1'b0);
        check("p1_same.pulse", {12'd0, dir_pulse}, 16'h0000);
        step(1'b1, 8'h3B, 1'b1);
        check("load.dir", {8'h00, dir}, 16'h008D);
        check("load.held", key_held, 16'h0000);
        check("load.pulse", {12'd0, dir_pulse}, 16'h0000);
        step(1'b1, 8'hF0, 1'b0);
        pulse_reset();
        @(posedge clock);
        #1;
        step(1'b1, 8'h23, 1'b0);
        check("post_rst.held", {15'd0, key_held[1]}, 16'd1);
        check("post_rst.pulse", {12'd0, dir_pulse}, 16'h0000);
        step(1'b1, 8'h29, 1'b0);
        check("unmapped.held", key_held, 16'h0002);
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 20) c = 8'hE0;
            else if (r < 35) c = 8'hF0;
            else if (r < 85) c = keys[$urandom_range(0, 3)][$urandom_range(0, 3)];
            else c = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
                @(posedge clock);
                #1;
            end else begin
                step($urandom_range(0, 9) < 7, c, $urandom_range(0, 49) == 0);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_direction_decoder.md
# ps2_direction_decoder

Converts the raw PS/2 scan-code byte stream from the keyboard receiver into registered heading commands for the four lightbike players. It is the inverse of the per-player key-binding map: it recognises each player's four direction make/break codes and tracks prefix state (E0 extended, F0 break). It also rejects 180° reversals and maintains each bike's current heading for the game-logic/movement block.

## Interface
Parameters:
- INIT_DIR, 8'h8D: reset/round-start heading, 2 bits per player, player p in bits [2p+1:2p]. Default gives p0=right, p1=left, p2=up, p3=down.
- REJECT_REVERSE, 1: when 1, a make code requesting the opposite of the current heading is ignored.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces reset state immediately.
- scan_code  in  8  byte from PS/2 receiver, valid only when scan_valid=1.
- scan_valid  in  1  one-cycle strobe per received byte.
- load_init  in  1  synchronous round restart: headings to INIT_DIR, held bits cleared, FSM to IDLE.
- dir  out  8  current heading per player, same packing as INIT_DIR; encoding 0=up, 1=right, 2=down, 3=left.
- dir_pulse  out  4  one-cycle strobe, bit p set in the cycle after player p's heading changed.
- key_held  out  16  bit 4p+d = player p currently holding the key for direction d.

## Operation
Key bindings (player: up/right/down/left):
- p0: 1D/23/1B/1C
- p1: 2C/33/34/2B
- p2: 43/4B/42/3B
- p3: 75/74/73/6B

Prefix FSM, with states IDLE, EXT, BRK, EXT_BRK. It advances only on scan_valid:
- E0 in any state -> EXT. A pending break flag is discarded.
- F0 in IDLE or BRK -> BRK. F0 in EXT or EXT_BRK -> EXT_BRK.
- Any other byte is a final code and returns the FSM to IDLE. BRK/EXT_BRK final = break; IDLE/EXT final = make.
- The E0 prefix does not affect matching: arrow keys (E0-prefixed) and keypad keys (unprefixed) with the same final code both map to p3.

Final-code handling:
- Unmapped codes: no effect.
- Break: clear the matching key_held bit. Heading is unchanged.
- Make: set the matching key_held bit. The heading request is then resolved as follows:
  - Requested direction == current heading: no change, no pulse.
  - REJECT_REVERSE=1 and requested == current XOR 2: rejected, no change, no pulse. The held bit is still set.
  - Otherwise: dir[p] <= requested and dir_pulse[p] <= 1.
- Typematic repeat makes follow the same rules and are therefore harmless.
- One byte affects at most one player, so at most one dir_pulse bit is set per cycle.

## Timing
- Reset values: dir=INIT_DIR, dir_pulse=0, key_held=0, FSM=IDLE.
- Latency: a byte presented with scan_valid in cycle N updates dir, dir_pulse and key_held at the rising edge ending cycle N. Outputs are visible in cycle N+1.
- dir_pulse lasts exactly one cycle. The next cycle it returns to 0 unless a new change occurs.
- Back-to-back scan_valid on consecutive cycles must be handled with no dropped bytes; each byte is processed in its own cycle.
- load_init in the same cycle as scan_valid: load_init wins, the byte is dropped, FSM goes to IDLE and dir_pulse=0.
- Reset asserted mid-sequence (e.g. after E0 F0) returns to IDLE. The following final byte is then treated as a make.
- All outputs are registered; there is no combinational path from scan_code to any output.

## Test plan
- After reset, with no input: dir=8'h8D, dir_pulse=0, key_held=0.
- Byte 1D with p0 at right: next cycle dir[1:0]=0 (up), dir_pulse=4'b0001, key_held[0]=1; the following cycle dir_pulse=0.
- Sequence 1C with p0 at right (REJECT_REVERSE=1): dir[1:0] stays 1, no pulse, key_held[3]=1. Then send F0 1C: key_held[3]=0, dir unchanged.
- Sequence E0 75 then E0 F0 75 for p3 (init down): first pair is rejected as a reverse, only the held bit toggles. Then send E0 6B: dir[7:6]=3, dir_pulse=4'b1000. Then send 73 (keypad, no E0): dir[7:6]=2, pulse again.
- Send 2B and 3B on consecutive cycles while holding load_init in the 3B cycle: p1 stays 3 (same as current, no pulse), 3B is dropped, dir returns to 8'h8D and key_held clears.
- Send F0, assert reset for one cycle, then send 23: after reset the FSM is in IDLE; 23 is treated as a make, p0 is already right, so no pulse and key_held[1]=1. Also send unmapped code 29: no output change.
